twiddle_addr_gen: RTL and testbench

- Drives the twiddle number sequence for one radix-2² SDF stage. It sits on the initiator side of the quarter-table twiddle converter: its `tw_addr` output feeds the converter's twiddle-number input.
- Counts accepted samples within an N-point frame and emits the twiddle number for the butterfly output order. Values are restricted to 0..3N/4-3, i.e. quadrants 0–2 only.
- Provides valid and frame-boundary strobes aligned with the address.

---
 rtl/twiddle_addr_gen_if.sv | 30 +++
 rtl/twiddle_addr_gen.sv | 86 ++++++++
 tb/tb_twiddle_addr_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/twiddle_addr_gen_if.sv
// Sample-side and twiddle-side signals of one SDF-stage twiddle address generator.
// The master drives samples in; the slave (the generator) drives twiddle numbers out.
interface twiddle_addr_gen_if #(
  parameter int unsigned LOG_N = 6
) ();
  logic             clear;
  logic             di_en;
  logic             tw_en;
  logic [LOG_N-1:0] tw_addr;
  logic             tw_first;
  logic             tw_last;

  modport master (
    output clear,
    output di_en,
    input  tw_en,
    input  tw_addr,
    input  tw_first,
    input  tw_last
  );

  modport slave (
    input  clear,
    input  di_en,
    output tw_en,
    output tw_addr,
    output tw_first,
    output tw_last
  );
endinterface

// File: rtl/twiddle_addr_gen.sv
// Twiddle number sequence for one radix-2^2 SDF stage: k*m per accepted sample, where m is
// the bit-reversed quadrant of the in-frame sample index. Latency 1 + OUT_FF cycles.
module twiddle_addr_gen #(
  parameter int unsigned LOG_N  = 6,
  parameter int unsigned OUT_FF = 1
) (
  input  logic              clock,
  input  logic              reset,
  twiddle_addr_gen_if.slave bus
);

  logic [LOG_N-1:0] cnt_q, cnt_d, cnt_eff;
  logic [1:0]       quad;
  logic [LOG_N-3:0] k;
  logic [LOG_N-1:0] k_x1, k_x2, addr_d;

  logic             s1_en_q, s1_first_q, s1_last_q;
  logic [LOG_N-1:0] s1_addr_q;

  // The product never exceeds 3*(N/4-1) < N, so it is formed directly in LOG_N bits.
  always_comb begin
    cnt_eff = bus.clear ? '0 : cnt_q;
    cnt_d   = bus.di_en ? cnt_eff + 1'b1 : cnt_eff;
    quad    = cnt_eff[LOG_N-1 -: 2];
    k       = cnt_eff[LOG_N-3:0];
    k_x1    = {2'b00, k};
    k_x2    = {1'b0, k, 1'b0};
    addr_d  = '0;
    case (quad)
      2'd0:    addr_d = '0;
      2'd1:    addr_d = k_x2;
      2'd2:    addr_d = k_x1;
      default: addr_d = k_x1 + k_x2;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      s1_en_q    <= 1'b0;
      s1_addr_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_en_q    <= bus.di_en;
      if (bus.di_en) begin
        s1_addr_q <= addr_d;
      end
      s1_first_q <= bus.di_en & (cnt_eff == '0);
      s1_last_q  <= bus.di_en & (&cnt_eff);
    end
  end

  if (OUT_FF != 0) begin : g_out_ff
    logic             s2_en_q, s2_first_q, s2_last_q;
    logic [LOG_N-1:0] s2_addr_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        s2_en_q    <= 1'b0;
        s2_addr_q  <= '0;
        s2_first_q <= 1'b0;
        s2_last_q  <= 1'b0;
      end else begin
        s2_en_q    <= s1_en_q;
        if (s1_en_q) begin
          s2_addr_q <= s1_addr_q;
        end
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end
    end

    assign bus.tw_en    = s2_en_q;
    assign bus.tw_addr  = s2_addr_q;
    assign bus.tw_first = s2_first_q;
    assign bus.tw_last  = s2_last_q;
  end else begin : g_no_out_ff
    assign bus.tw_en    = s1_en_q;
    assign bus.tw_addr  = s1_addr_q;
    assign bus.tw_first = s1_first_q;
    assign bus.tw_last  = s1_last_q;
  end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Directed bench for twiddle_addr_gen: three instances (N=16 without/with output register,
// N=64) share one stimulus stream and are checked against a per-instance cycle model.
module tb_twiddle_addr_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  twiddle_addr_gen_if #(.LOG_N(4)) if0 ();
  twiddle_addr_gen_if #(.LOG_N(4)) if1 ();
  twiddle_addr_gen_if #(.LOG_N(6)) if2 ();

  twiddle_addr_gen #(.LOG_N(4), .OUT_FF(0)) u0 (.clock(clock), .reset(reset), .bus(if0));
  twiddle_addr_gen #(.LOG_N(4), .OUT_FF(1)) u1 (.clock(clock), .reset(reset), .bus(if1));
  twiddle_addr_gen #(.LOG_N(6), .OUT_FF(0)) u2 (.clock(clock), .reset(reset), .bus(if2));

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-derived N=16 sequence: quadrant multipliers 0,2,1,3 applied to k=0..3.
  int seq16[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
  int logn[3]   = '{4, 4, 6};
  int outff[3]  = '{0, 1, 0};

  int m_cnt[3];
  int m1_en[3], m1_addr[3], m1_first[3], m1_last[3];
  int m2_en[3], m2_addr[3], m2_first[3], m2_last[3];

  int n_first0;
  int n_valid6;
  int seen45;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_addr(input int ln, input int c);
    int q4;
    int q;
    int k;
    if (ln == 4) return seq16[c];
    q4 = (1 << ln) / 4;
    q  = c / q4;
    k  = c % q4;
    if (q == 1) return 2 * k;
    if (q == 2) return k;
    if (q == 3) return 3 * k;
    return 0;
  endfunction

  task automatic model(input int d, input bit en, input bit clr, input bit rst);
    int ec;
    int n;
    n = 1 << logn[d];
    if (rst) begin
      m_cnt[d] = 0;
      m1_en[d] = 0; m1_addr[d] = 0; m1_first[d] = 0; m1_last[d] = 0;
      m2_en[d] = 0; m2_addr[d] = 0; m2_first[d] = 0; m2_last[d] = 0;
    end else begin
      ec = clr ? 0 : m_cnt[d];
      m2_en[d] = m1_en[d];
      if (m1_en[d] != 0) m2_addr[d] = m1_addr[d];
      m2_first[d] = m1_first[d];
      m2_last[d]  = m1_last[d];
      m1_en[d] = int'(en);
      if (en) m1_addr[d] = ref_addr(logn[d], ec);
      m1_first[d] = int'(en && ec == 0);
      m1_last[d]  = int'(en && ec == n - 1);
      m_cnt[d] = en ? (ec + 1) % n : ec;
    end
  endtask

  task automatic check_dut(input int d, input logic en, input logic [31:0] addr,
                           input logic first, input logic last);
    int e_en, e_addr, e_first, e_last;
    e_en    = outff[d] != 0 ? m2_en[d]    : m1_en[d];
    e_addr  = outff[d] != 0 ? m2_addr[d]  : m1_addr[d];
    e_first = outff[d] != 0 ? m2_first[d] : m1_first[d];
    e_last  = outff[d] != 0 ? m2_last[d]  : m1_last[d];
    chk($sformatf("u%0d.tw_en", d), {31'b0, en}, e_en);
    chk($sformatf("u%0d.tw_addr", d), addr, e_addr);
    chk($sformatf("u%0d.tw_first", d), {31'b0, first}, e_first);
    chk($sformatf("u%0d.tw_last", d), {31'b0, last}, e_last);
    if (en === 1'b1) begin
      chk($sformatf("u%0d.quadrant3", d), {31'b0, ((addr >> (logn[d] - 2)) == 3)}, 0);
    end
  endtask

  task automatic step(input bit en, input bit clr, input bit rst);
    reset     = rst;
    if0.di_en = en; if0.clear = clr;
    if1.di_en = en; if1.clear = clr;
    if2.di_en = en; if2.clear = clr;
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) model(d, en, clr, rst);
    check_dut(0, if0.tw_en, {28'b0, if0.tw_addr}, if0.tw_first, if0.tw_last);
    check_dut(1, if1.tw_en, {28'b0, if1.tw_addr}, if1.tw_first, if1.tw_last);
    check_dut(2, if2.tw_en, {26'b0, if2.tw_addr}, if2.tw_first, if2.tw_last);
    if (if0.tw_en === 1'b1 && if0.tw_first === 1'b1) n_first0++;
    if (if2.tw_en === 1'b1) n_valid6++;
    if (if2.tw_en === 1'b1 && if2.tw_last === 1'b1 && if2.tw_addr == 6'd45) seen45 = 1;
  endtask

  initial begin
    logic [6:0] pat;
    int acc;
    if0.di_en = 1'b0; if0.clear = 1'b0;
    if1.di_en = 1'b0; if1.clear = 1'b0;
    if2.di_en = 1'b0; if2.clear = 1'b0;

    // Reset, then a full N=16 frame of back-to-back samples.
    step(0, 0, 1);
    step(1, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0);
      chk("seq16_direct", {28'b0, if0.tw_addr}, seq16[i]);
      if (i == 0)  chk("first_direct", {31'b0, if0.tw_first}, 1);
      if (i == 15) chk("last_direct", {31'b0, if0.tw_last}, 1);
      if (i >= 1)  chk("seq16_ff_direct", {28'b0, if1.tw_addr}, seq16[i-1]);
    end
    step(0, 0, 0);
    chk("ff_last_direct", {31'b0, if1.tw_last}, 1);
    step(0, 0, 0);

    // Gapped input across two frames.
    step(0, 0, 1);
    n_first0 = 0;
    pat = 7'b1011001;
    for (int i = 0; i < 56; i++) step(pat[i % 7], 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("gap_frames_first", n_first0, 2);

    // Clear mid-frame at sample 7.
    step(0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    step(1, 1, 0);
    chk("clear_addr", {28'b0, if0.tw_addr}, 0);
    chk("clear_first", {31'b0, if0.tw_first}, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("clear_seq5", {28'b0, if0.tw_addr}, 2);
    step(0, 0, 0);

    // Reset at sample 9 with di_en held high.
    step(0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    step(1, 0, 1);
    chk("rst_mid_en", {31'b0, if1.tw_en}, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Three random-gapped N=64 frames.
    step(0, 0, 1);
    n_valid6 = 0;
    seen45   = 0;
    acc      = 0;
    for (int i = 0; i < 2000 && acc < 192; i++) begin
      bit en;
      en = 1'($urandom_range(0, 1));
      step(en, 0, 0);
      if (en) acc++;
    end
    step(0, 0, 0);
    chk("rand_accepted", acc, 192);
    chk("rand_valid6", n_valid6, 192);
    chk("rand_seen45", seen45, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
